// File: rtl/score_display.sv
// Binary score to multiplexed common-anode 7-segment display.
// Sequential double-dabble conversion, leading-zero blanking, saturation.
module score_display #(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  score,
  output logic [7:0]        SEG,
  output logic [DIGITS-1:0] AN,
  output logic              busy,
  output logic              overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BIN_W-1:0]   last_q, last_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               overflow_q, overflow_d;
  logic [PS_W-1:0]    ps_q, ps_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  an_q, an_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic               ovf_step;
  logic [DIGITS-1:0]  blank;
  logic [3:0]         nib;
  logic               blank_sel;

  // One double-dabble step: add 3 to every nibble >= 5, flag a lost MSB.
  always_comb begin
    logic [3:0] t;
    bcd_adj = '0;
    t = '0;
    for (int i = 0; i < DIGITS; i++) begin
      t = bcd_q[4*i +: 4];
      bcd_adj[4*i +: 4] = (t >= 4'd5) ? t + 4'd3 : t;
    end
    ovf_step = bcd_adj[BCD_W-1];
  end

  // Converter FSM: next state, shift datapath and display load.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    last_d     = last_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (score != last_q) begin
          bin_d   = score;
          last_d  = score;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        ovf_d = ovf_q | ovf_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_d     = ovf_q ? {DIGITS{4'h9}} : bcd_q;
        overflow_d = ovf_q;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Leading-zero mask: digit i blanks when it and all above are zero.
  always_comb begin
    logic run;
    run   = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run = run & (disp_q[4*i +: 4] == 4'd0);
      blank[i] = (i > 0) && run && (BLANK_LZ != 0) && !overflow_q;
    end
  end

  // Scan timing, digit selection and segment/anode next values.
  always_comb begin
    nib       = '0;
    blank_sel = 1'b0;
    an_d      = '1;
    if (ps_q == PS_W'(SCAN_DIV - 1)) begin
      ps_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      ps_d  = ps_q + PS_W'(1);
      idx_d = idx_q;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = disp_q[4*i +: 4];
        blank_sel = blank[i];
        an_d[i]   = blank[i];
      end
    end
    unique case (nib)
      4'd0:    seg_d = 8'hC0;
      4'd1:    seg_d = 8'hF9;
      4'd2:    seg_d = 8'hA4;
      4'd3:    seg_d = 8'hB0;
      4'd4:    seg_d = 8'h99;
      4'd5:    seg_d = 8'h92;
      4'd6:    seg_d = 8'h82;
      4'd7:    seg_d = 8'hF8;
      4'd8:    seg_d = 8'h80;
      4'd9:    seg_d = 8'h90;
      default: seg_d = 8'hFF;
    endcase
    if (blank_sel) begin
      seg_d = 8'hFF;
    end
  end

  // All state registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      last_q     <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      ps_q       <= '0;
      idx_q      <= '0;
      seg_q      <= 8'hFF;
      an_q       <= '1;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      last_q     <= last_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      ps_q       <= ps_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign SEG      = seg_q;
  assign AN       = an_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: three instances cover
// blanking on/off and a wider 20-bit / 6-digit configuration.
module tb_score_display;

  localparam logic [7:0] SEGT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] score_a = '0;
  logic [15:0] score_b = '0;
  logic [19:0] score_c = '0;
  logic [7:0]  seg_a, seg_b, seg_c;
  logic [3:0]  an_a, an_b;
  logic [5:0]  an_c;
  logic        busy_a, busy_b, busy_c;
  logic        ovf_a, ovf_b, ovf_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  score_display #(.BIN_W(16), .DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst(rst), .score(score_a), .SEG(seg_a), .AN(an_a),
    .busy(busy_a), .overflow(ovf_a)
  );

  score_display #(.BIN_W(16), .DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst(rst), .score(score_b), .SEG(seg_b), .AN(an_b),
    .busy(busy_b), .overflow(ovf_b)
  );

  score_display #(.BIN_W(20), .DIGITS(6), .SCAN_DIV(4), .BLANK_LZ(1)) dut_c (
    .clk(clk), .rst(rst), .score(score_c), .SEG(seg_c), .AN(an_c),
    .busy(busy_c), .overflow(ovf_c)
  );

  function automatic logic [7:0] an_of(input int w);
    case (w)
      0:       return {4'hF, an_a};
      1:       return {4'hF, an_b};
      default: return {2'b11, an_c};
    endcase
  endfunction

  function automatic logic [7:0] seg_of(input int w);
    case (w)
      0:       return seg_a;
      1:       return seg_b;
      default: return seg_c;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic ovf_of(input int w);
    case (w)
      0:       return ovf_a;
      1:       return ovf_b;
      default: return ovf_c;
    endcase
  endfunction

  task automatic set_score(input int w, input int val);
    case (w)
      0:       score_a = 16'(val);
      1:       score_b = 16'(val);
      default: score_c = 20'(val);
    endcase
  endtask

  // Apply a score and measure the busy pulse length.
  task automatic run_conv(input int w, input int val, input int exp_len,
                          input string name);
    int len;
    int k;
    @(negedge clk);
    set_score(w, val);
    k = 0;
    while (busy_of(w) !== 1'b1 && k < 4) begin
      @(negedge clk);
      k++;
    end
    len = 0;
    while (busy_of(w) === 1'b1 && len < 100) begin
      @(negedge clk);
      len++;
    end
    tests++;
    if (len !== exp_len) begin
      fails++;
      $display("FAIL %s busy_len: got %0d want %0d", name, len, exp_len);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_ovf(input int w, input logic exp, input string name);
    tests++;
    if (ovf_of(w) !== exp) begin
      fails++;
      $display("FAIL %s overflow: got %b want %b", name, ovf_of(w), exp);
    end
  endtask

  // Observe one full scan and compare each slot against the decimal value.
  task automatic check_scan(input int w, input longint val, input logic ov,
                            input string name);
    int nd;
    bit blz;
    longint v;
    longint p;
    logic [7:0] exp_seg [8];
    bit exp_blank [8];
    int seen [8];
    int bad [8];
    int ones;
    int exp_ones;
    int zeros;
    int k;
    logic [7:0] an;
    logic [7:0] sg;
    nd = (w == 2) ? 6 : 4;
    blz = (w != 1);
    v = val;
    if (ov) begin
      v = 1;
      for (int i = 0; i < nd; i++) v = v * 10;
      v = v - 1;
    end
    p = 1;
    exp_ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_seg[i] = SEGT[int'((v / p) % 10)];
      exp_blank[i] = blz && (i > 0) && !ov && ((v / p) == 0);
      if (i < nd && exp_blank[i]) exp_ones += 4;
      p = p * 10;
      seen[i] = 0;
      bad[i] = 0;
    end
    ones = 0;
    for (int c = 0; c < nd * 4; c++) begin
      @(negedge clk);
      an = an_of(w);
      sg = seg_of(w);
      if (an == 8'hFF) begin
        ones++;
      end else begin
        zeros = 0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
          if (!an[i]) begin
            zeros++;
            k = i;
          end
        end
        seen[k]++;
        if (zeros != 1 || exp_blank[k] || sg !== exp_seg[k]) bad[k]++;
      end
    end
    for (int i = 0; i < nd; i++) begin
      tests++;
      if (seen[i] != (exp_blank[i] ? 0 : 4) || bad[i] != 0) begin
        fails++;
        $display("FAIL %s digit%0d: seen %0d bad %0d want seen %0d seg %h",
                 name, i, seen[i], bad[i], exp_blank[i] ? 0 : 4,
                 exp_seg[i]);
      end
    end
    tests++;
    if (ones != exp_ones) begin
      fails++;
      $display("FAIL %s blank_slots: got %0d want %0d", name, ones,
               exp_ones);
    end
  endtask

  task automatic test_reset();
    int rises;
    logic [2:0] prev;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    score_a = 16'd1234;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (seg_a !== 8'hFF || an_a !== 4'hF || busy_a !== 1'b0 ||
        ovf_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_a: seg %h an %h busy %b ovf %b want FF F 0 0",
               seg_a, an_a, busy_a, ovf_a);
    end
    tests++;
    if (seg_c !== 8'hFF || an_c !== 6'h3F) begin
      fails++;
      $display("FAIL reset_c: seg %h an %h want FF 3F", seg_c, an_c);
    end
    score_a = '0;
    rst = 1'b0;
    rises = 0;
    prev = 3'b000;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (busy_a && !prev[0]) rises++;
      if (busy_b && !prev[1]) rises++;
      if (busy_c && !prev[2]) rises++;
      prev = {busy_c, busy_b, busy_a};
    end
    tests++;
    if (rises != 0) begin
      fails++;
      $display("FAIL zero_no_busy: got %0d pulses want 0", rises);
    end
    check_scan(0, 0, 1'b0, "zero_a");
    check_scan(1, 0, 1'b0, "zero_b");
    check_scan(2, 0, 1'b0, "zero_c");
  endtask

  task automatic test_basic();
    run_conv(0, 1234, 17, "b1234");
    check_ovf(0, 1'b0, "b1234");
    check_scan(0, 1234, 1'b0, "b1234");
  endtask

  task automatic test_blanking();
    run_conv(0, 7, 17, "blank7_a");
    check_scan(0, 7, 1'b0, "blank7_a");
    run_conv(1, 7, 17, "noblank7_b");
    check_scan(1, 7, 1'b0, "noblank7_b");
    run_conv(0, 1005, 17, "b1005");
    check_scan(0, 1005, 1'b0, "b1005");
  endtask

  task automatic test_overflow();
    run_conv(0, 9999, 17, "o9999");
    check_ovf(0, 1'b0, "o9999");
    check_scan(0, 9999, 1'b0, "o9999");
    run_conv(0, 10000, 17, "o10000");
    check_ovf(0, 1'b1, "o10000");
    check_scan(0, 0, 1'b1, "o10000");
    run_conv(0, 65535, 17, "o65535");
    check_ovf(0, 1'b1, "o65535");
    check_scan(0, 0, 1'b1, "o65535");
    run_conv(0, 42, 17, "o42");
    check_ovf(0, 1'b0, "o42");
    check_scan(0, 42, 1'b0, "o42");
  endtask

  task automatic test_mid_change();
    int rises;
    int since;
    bit prev;
    bit got_first;
    logic [15:0] first_disp;
    @(negedge clk);
    score_a = 16'd100;
    rises = 0;
    since = 0;
    prev = 1'b0;
    got_first = 1'b0;
    first_disp = '0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (busy_a && !prev) rises++;
      if (!busy_a && prev && !got_first) begin
        got_first = 1'b1;
        first_disp = dut_a.disp_q;
      end
      if (rises == 1 && busy_a) begin
        since++;
        if (since == 5) score_a = 16'd200;
      end
      prev = busy_a;
    end
    tests++;
    if (rises != 2) begin
      fails++;
      $display("FAIL mid_pulses: got %0d want 2", rises);
    end
    tests++;
    if (first_disp !== 16'h0100) begin
      fails++;
      $display("FAIL mid_first_disp: got %h want 0100", first_disp);
    end
    check_scan(0, 200, 1'b0, "mid_final");
  endtask

  task automatic test_param();
    run_conv(2, 999999, 21, "p999999");
    check_ovf(2, 1'b0, "p999999");
    check_scan(2, 999999, 1'b0, "p999999");
    run_conv(2, 1000000, 21, "p1000000");
    check_ovf(2, 1'b1, "p1000000");
    check_scan(2, 0, 1'b1, "p1000000");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blanking();
    test_overflow();
    test_mid_change();
    test_param();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
